vga_timing_gen: RTL
===================

# vga_timing_gen

Parametrised VGA raster timing generator: successor to the fixed 640x480 timing block, with the full mode and both sync polarities set by parameters. Drives a pixel clock enable so it can run from a faster system clock. Produces registered counters, syncs, blanking, data-enable and line/frame strobes for the chess board renderer and the pixel pipeline. Sits at the head of the display path; every downstream draw stage keys off its `hcount`/`vcount`.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (≥1)
- `H_SYNC`, 96, hsync width (≥1)
- `H_BP`, 48, horizontal back porch (≥1)
- `V_ACTIVE`, 480, visible lines
- `V_FP`, 10; `V_SYNC`, 2; `V_BP`, 33: vertical porches and sync in lines (each ≥1)
- `H_SYNC_POL`, `V_SYNC_POL`, 0, 1 = active-high sync, 0 = active-low
- `CW`, 11, counter width; elaboration error unless 2^CW ≥ max(H_TOTAL, V_TOTAL)
- `FRAME_W`, 8, frame counter width (used only with `VGA_TIMING_FRAME_CNT_EN`)
- `clk` in 1: single clock; all logic on rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `ce` in 1: pixel advance enable; tie high when `clk` is the pixel clock
- `hcount` out CW: current column, 0..H_TOTAL-1
- `vcount` out CW: current line, 0..V_TOTAL-1
- `hsync`, `vsync` out 1: syncs at configured polarity
- `hblnk`, `vblnk` out 1: high outside the active region of each axis
- `de` out 1: `!hblnk && !vblnk`
- `line_start` out 1: one-`clk` strobe when `hcount` becomes 0
- `frame_start` out 1: one-`clk` strobe when (`hcount`,`vcount`) becomes (0,0)
- `frame_cnt` out FRAME_W: frame index

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Defaults give 800x525.
- On each `clk` edge with `ce`=1: `hcount` increments; at H_TOTAL-1 it wraps to 0 and `vcount` increments; `vcount` wraps from V_TOTAL-1 to 0. With `ce`=0, every register except the strobes holds.
- All outputs are registered, decoded from next-state counters, so they always match the `hcount`/`vcount` of the same cycle. No lag between counters and syncs.
- hsync asserted for hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]. vsync asserted for vcount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], for the whole line.
- hblnk = hcount ≥ H_ACTIVE; vblnk = vcount ≥ V_ACTIVE.
- Strobes are high for exactly one `clk` cycle, the first cycle the new position is presented. They clear on the next edge regardless of `ce`.

## Timing
- Reset state is the last raster position:
  - `hcount`=H_TOTAL-1, `vcount`=V_TOTAL-1
  - `hblnk`=`vblnk`=1, `de`=0
  - syncs at inactive level
  - strobes 0
  - `frame_cnt` all ones
- First `ce` edge after reset release presents (0,0) with `de`=1 and `line_start`=`frame_start`=1.
- Reset asserted mid-frame forces the reset state immediately, without a clock edge.
- Release is synchronised by the integration. The block itself requires release not coincident with a `clk` edge.
- Latency from a `ce` edge to a position change on all outputs: 0 extra cycles (registered at that edge).
- Default frame: 420000 `ce` cycles; hsync 96, vsync 2x800 `ce` cycles.

## Configuration
- `VGA_TIMING_FRAME_CNT_EN` defined:
  - `frame_cnt` is a FRAME_W-bit register that increments on every edge producing `frame_start`.
  - Wraps modulo 2^FRAME_W.
  - First frame after reset reads 0.
- Undefined: `frame_cnt` tied to 0; no register is synthesised.

## Structure
- Shared package `vga_pkg`: timing constants for 640x480@60 (defaults above) and 800x600@60, plus the polarity encoding constants.
- One sub-module `vga_axis_cnt`: generic single-axis counter plus decoder (ACTIVE/FP/SYNC/BP/POL, advance input, wrap output). It is instantiated twice:
  - horizontal: advance = `ce`
  - vertical: advance = `ce` && horizontal wrap

## Test plan
- Reset and start:
  - Hold `rst_n`=0 → `hcount`=799, `vcount`=524, `de`=0, `hsync`=`vsync`=1.
  - Release with `ce`=1 → next cycle (0,0), `de`=1, `line_start`=`frame_start`=1.
- Line timing:
  - `hsync` low exactly for hcount 656..751.
  - `de` high 640 cycles per line on lines 0..479 and never on 480..524.
- Frame timing:
  - `vsync` low exactly on lines 490..491.
  - `frame_start` period = 420000 `ce` cycles.
  - `line_start` count per frame = 525.
- `ce`=1,0 alternating:
  - Frame period 840000 `clk`.
  - All outputs frozen in `ce`=0 cycles.
  - Strobes one `clk` wide.
- Async reset mid-frame: drop `rst_n` at (300,200) between edges → outputs take reset values before the next `clk` edge.
- Tiny mode with `VGA_TIMING_FRAME_CNT_EN`:
  - Parameters: H 4/1/2/1, V 3/1/1/1, pol=1, FRAME_W=2.
  - Expect hsync high at hcount 5..6 and vsync high on line 4.
  - `frame_cnt` sequence 0,1,2,3,0 over five frames.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing constants, polarity encoding and axis-decode helpers.
// Covers 640x480@60 (generator defaults) and 800x600@60.
package vga_pkg;

  localparam int POL_ACTIVE_LOW  = 0;
  localparam int POL_ACTIVE_HIGH = 1;

  // 640x480@60, 25.175 MHz pixel clock, 800x525 total
  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP     = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BP     = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP     = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BP     = 33;
  localparam int VGA640_H_POL    = POL_ACTIVE_LOW;
  localparam int VGA640_V_POL    = POL_ACTIVE_LOW;

  // 800x600@60, 40 MHz pixel clock, 1056x628 total
  localparam int SVGA800_H_ACTIVE = 800;
  localparam int SVGA800_H_FP     = 40;
  localparam int SVGA800_H_SYNC   = 128;
  localparam int SVGA800_H_BP     = 88;
  localparam int SVGA800_V_ACTIVE = 600;
  localparam int SVGA800_V_FP     = 1;
  localparam int SVGA800_V_SYNC   = 4;
  localparam int SVGA800_V_BP     = 23;
  localparam int SVGA800_H_POL    = POL_ACTIVE_HIGH;
  localparam int SVGA800_V_POL    = POL_ACTIVE_HIGH;

  typedef enum logic [1:0] {
    AXIS_ACTIVE,
    AXIS_FP,
    AXIS_SYNC,
    AXIS_BP
  } axis_region_e;

  // Back porch is whatever lies past the sync pulse, so it needs no bound here.
  function automatic axis_region_e axis_region(input int unsigned pos,
                                               input int unsigned active,
                                               input int unsigned fp,
                                               input int unsigned sync);
    if (pos < active) begin
      return AXIS_ACTIVE;
    end else if (pos < active + fp) begin
      return AXIS_FP;
    end else if (pos < active + fp + sync) begin
      return AXIS_SYNC;
    end
    return AXIS_BP;
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic bit width_fits(input int unsigned cw, input int unsigned total);
    longint unsigned lim;
    lim = longint'(1) << cw;
    return lim >= longint'(total);
  endfunction

endpackage

// File: rtl/vga_axis_cnt.sv
// Single raster axis: wrapping position counter with registered sync/blank
// decoded from the next-state count so they line up with the count output.
module vga_axis_cnt
  import vga_pkg::*;
#(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter int POL    = 0,
  parameter int CW     = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          adv_i,
  output logic [CW-1:0] count_o,
  output logic          sync_o,
  output logic          blnk_o,
  output logic          active_next_o,
  output logic          wrap_o
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;
  localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);
  localparam logic SYNC_ON = POL[0];

  if (ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1) begin : g_len_check
    $error("vga_axis_cnt: ACTIVE, FP, SYNC and BP must all be at least 1");
  end
  if (!width_fits(CW, TOTAL)) begin : g_cw_check
    $error("vga_axis_cnt: CW too narrow for axis total %0d", TOTAL);
  end

  logic [CW-1:0] count_q, count_d;
  logic          sync_q, sync_d;
  logic          blnk_q, blnk_d;
  logic          at_last;
  axis_region_e  region_d;

  assign at_last = (count_q == LAST);
  assign wrap_o  = adv_i && at_last;

  always_comb begin
    count_d = count_q;
    if (adv_i) begin
      count_d = at_last ? '0 : count_q + CW'(1);
    end
    region_d = axis_region(int'(count_d), ACTIVE, FP, SYNC);
    sync_d   = (region_d == AXIS_SYNC) ? SYNC_ON : ~SYNC_ON;
    blnk_d   = (region_d != AXIS_ACTIVE);
  end

  assign active_next_o = ~blnk_d;

  // Reset parks on the last position (back porch), so the first advance
  // lands on position 0 and sync is inactive while held in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= LAST;
      sync_q  <= ~SYNC_ON;
      blnk_q  <= 1'b1;
    end else begin
      count_q <= count_d;
      sync_q  <= sync_d;
      blnk_q  <= blnk_d;
    end
  end

  assign count_o = count_q;
  assign sync_o  = sync_q;
  assign blnk_o  = blnk_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with pixel clock enable.
// Optional frame counter enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = VGA640_H_ACTIVE,
  parameter int H_FP       = VGA640_H_FP,
  parameter int H_SYNC     = VGA640_H_SYNC,
  parameter int H_BP       = VGA640_H_BP,
  parameter int V_ACTIVE   = VGA640_V_ACTIVE,
  parameter int V_FP       = VGA640_V_FP,
  parameter int V_SYNC     = VGA640_V_SYNC,
  parameter int V_BP       = VGA640_V_BP,
  parameter int H_SYNC_POL = VGA640_H_POL,
  parameter int V_SYNC_POL = VGA640_V_POL,
  parameter int CW         = 11,
  parameter int FRAME_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ce,
  output logic [CW-1:0]      hcount,
  output logic [CW-1:0]      vcount,
  output logic               hsync,
  output logic               vsync,
  output logic               hblnk,
  output logic               vblnk,
  output logic               de,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (!width_fits(CW, max2(H_TOTAL, V_TOTAL))) begin : g_cw_check
    $error("vga_timing_gen: CW=%0d cannot hold max(%0d, %0d)", CW, H_TOTAL, V_TOTAL);
  end
  if (FRAME_W < 1) begin : g_fw_check
    $error("vga_timing_gen: FRAME_W must be at least 1");
  end

  logic h_wrap, v_wrap, v_adv;
  logic h_active_d, v_active_d;

  assign v_adv = ce && h_wrap;

  vga_axis_cnt #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP),
    .POL(H_SYNC_POL), .CW(CW)
  ) u_h_axis (
    .clk          (clk),
    .rst_n        (rst_n),
    .adv_i        (ce),
    .count_o      (hcount),
    .sync_o       (hsync),
    .blnk_o       (hblnk),
    .active_next_o(h_active_d),
    .wrap_o       (h_wrap)
  );

  vga_axis_cnt #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP),
    .POL(V_SYNC_POL), .CW(CW)
  ) u_v_axis (
    .clk          (clk),
    .rst_n        (rst_n),
    .adv_i        (v_adv),
    .count_o      (vcount),
    .sync_o       (vsync),
    .blnk_o       (vblnk),
    .active_next_o(v_active_d),
    .wrap_o       (v_wrap)
  );

  logic de_q, de_d;
  logic line_start_q, line_start_d;
  logic frame_start_q, frame_start_d;

  // h_wrap already carries ce, and v_wrap only fires on a line wrap, so the
  // strobes drop on the very next edge even when ce is low.
  always_comb begin
    de_d          = h_active_d && v_active_d;
    line_start_d  = h_wrap;
    frame_start_d = v_wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_q          <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      de_q          <= de_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign de          = de_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;

  // Starts at all ones so the first frame after reset reads 0.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (v_wrap) begin
      frame_cnt_d = frame_cnt_q + FRAME_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '1;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = '0;
`endif

endmodule
